ppi_bus_master: RTL

PPI_BUS_MASTER -- requirements
Module: ppi_bus_master

---
 rtl/ppi_pkg.sv | 38 +++
 rtl/ppi_phase_timer.sv | 38 +++
 rtl/ppi_bus_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255-style PPI bus master.
// The INIT state exists only when PPI_MASTER_INIT_EN is defined.
package ppi_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
`ifdef PPI_MASTER_INIT_EN
    , ST_INIT = 3'd5
`endif
  } state_e;

  // Counter value loaded on entry to a state; the state lasts reload+1 cycles.
  function automatic logic [CNT_W-1:0] phase_reload(input state_e st,
                                                    input int unsigned setup_cyc,
                                                    input int unsigned strobe_cyc,
                                                    input int unsigned hold_cyc);
    logic [CNT_W-1:0] val;
    case (st)
      ST_SETUP:  val = CNT_W'(setup_cyc - 32'd1);
      ST_STROBE: val = CNT_W'(strobe_cyc - 32'd1);
      ST_HOLD:   val = CNT_W'(hold_cyc - 32'd1);
      default:   val = {CNT_W{1'b0}};
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// Loadable down-counter that times each bus phase; zero_o flags the last
// cycle of the current phase.
module ppi_phase_timer
  import ppi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: reload wins, otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ppi_bus_master.sv
// Host-to-PPI bus master generating nCS/nRD/nWR cycles with programmable
// setup/strobe/hold. Define PPI_MASTER_INIT_EN for a start-up control write.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter logic [7:0]  INIT_CTRL  = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nCS,
  output logic       nRD,
  output logic       nWR,
  output logic [1:0] A,
  output logic [7:0] Dout,
  output logic       DEn,
  input  logic [7:0] Din
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ncs_q, ncs_d;
  logic             nrd_q, nrd_d;
  logic             nwr_q, nwr_d;
  logic [1:0]       a_q, a_d;
  logic [7:0]       dout_q, dout_d;
  logic             den_q, den_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             active_s;
  logic             zero_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;

`ifdef PPI_MASTER_INIT_EN
  logic init_pending_q, init_pending_d;
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  ppi_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (zero_s)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, request latch and the bus values for the state being entered
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef PPI_MASTER_INIT_EN
    init_pending_d = init_pending_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req && ready_q) begin
          state_d = ST_SETUP;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (zero_s) begin
          state_d = ST_STROBE;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (zero_s) begin
          state_d = ST_HOLD;
          if (!we_q) begin
            rdata_d = Din;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (zero_s) begin
`ifdef PPI_MASTER_INIT_EN
          // the start-up write is internal: no done pulse for it
          if (init_pending_q) begin
            state_d        = ST_IDLE;
            init_pending_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef PPI_MASTER_INIT_EN
      ST_INIT: begin
        state_d = ST_SETUP;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = INIT_CTRL;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // outputs are registered from the next state so they track state_q exactly
    active_s   = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    ncs_d      = !active_s;
    nrd_d      = !((state_d == ST_STROBE) && !we_d);
    nwr_d      = !((state_d == ST_STROBE) && we_d);
    a_d        = active_s ? addr_d : 2'b00;
    dout_d     = active_s ? wdata_d : 8'h00;
    den_d      = active_s && we_d;
    done_d     = (state_d == ST_DONE);
    ready_d    = (state_d == ST_IDLE);
    load_s     = (state_d != state_q);
    load_val_s = phase_reload(state_d, SETUP_CYC, STROBE_CYC, HOLD_CYC);
  end

  // request latch, read data and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b1;
      addr_q  <= ADDR_CTRL;
      wdata_q <= INIT_CTRL;
      rdata_q <= 8'h00;
      ncs_q   <= 1'b1;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      a_q     <= 2'b00;
      dout_q  <= 8'h00;
      den_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ncs_q   <= ncs_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

`ifdef PPI_MASTER_INIT_EN
  // start-up write outstanding flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_pending_q <= 1'b1;
    end else begin
      init_pending_q <= init_pending_d;
    end
  end
`endif

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign nCS   = ncs_q;
  assign nRD   = nrd_q;
  assign nWR   = nwr_q;
  assign A     = a_q;
  assign Dout  = dout_q;
  assign DEn   = den_q;

endmodule
